// File: rtl/branch_predictor_gshare.sv
// Fetch-stage branch predictor: a table of saturating counters indexed by PC (bimodal)
// or PC XOR speculative global history (gshare), trained and repaired from EX.
module branch_predictor_gshare #(
  parameter int  ENTRIES  = 64,
  parameter int  CNT_BITS = 2,
  parameter int  GHR_BITS = 6,
  parameter int  MODE     = 1,
  parameter int  PC_LSB   = 2,
  localparam int IDX_W    = $clog2(ENTRIES)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                pc_valid,
  input  logic [31:0]         pc,
  output logic                pred_taken,
  output logic [IDX_W-1:0]    pred_index,
  output logic [GHR_BITS-1:0] pred_ghr,
  input  logic                upd_valid,
  input  logic [IDX_W-1:0]    upd_index,
  input  logic [GHR_BITS-1:0] upd_ghr,
  input  logic                upd_pred_taken,
  input  logic                upd_actual_taken,
  output logic                flush_pipeline,
  output logic [31:0]         stat_branches,
  output logic [31:0]         stat_mispredicts
);

  localparam logic [CNT_BITS-1:0] CNT_INIT = CNT_BITS'((1 << (CNT_BITS - 1)) - 1);
  localparam logic [CNT_BITS-1:0] CNT_MAX  = '1;

  if (ENTRIES < 4 || (1 << IDX_W) != ENTRIES) begin : g_bad_entries
    $error("ENTRIES must be a power of two and at least 4");
  end
  if (CNT_BITS < 2 || CNT_BITS > 4) begin : g_bad_cnt
    $error("CNT_BITS must be in 2..4");
  end
  if (GHR_BITS < 1 || GHR_BITS > IDX_W) begin : g_bad_ghr
    $error("GHR_BITS must be in 1..log2(ENTRIES)");
  end
  if (PC_LSB < 0 || PC_LSB + IDX_W > 32) begin : g_bad_pc_lsb
    $error("PC_LSB + log2(ENTRIES) must fit within the 32-bit PC");
  end

  function automatic logic [CNT_BITS-1:0] cnt_train(input logic [CNT_BITS-1:0] c,
                                                    input logic up);
    logic [CNT_BITS-1:0] r;
    if (up) r = (c == CNT_MAX) ? c : c + CNT_BITS'(1);
    else    r = (c == '0)      ? c : c - CNT_BITS'(1);
    return r;
  endfunction

  function automatic logic [31:0] stat_inc(input logic [31:0] s);
    return (s == 32'hFFFF_FFFF) ? s : s + 32'd1;
  endfunction

  // Works for GHR_BITS=1 too: the old history falls off the top of the concatenation.
  function automatic logic [GHR_BITS-1:0] ghr_shift(input logic [GHR_BITS-1:0] g,
                                                    input logic b);
    logic [GHR_BITS:0] t;
    t = {g, b};
    return t[GHR_BITS-1:0];
  endfunction

  logic [CNT_BITS-1:0] cnt_q [ENTRIES];
  logic [CNT_BITS-1:0] cnt_d [ENTRIES];
  logic [GHR_BITS-1:0] ghr_q, ghr_d;
  logic                flush_q, flush_d;
  logic [31:0]         branches_q, branches_d;
  logic [31:0]         mispredicts_q, mispredicts_d;

  logic [IDX_W-1:0]    base_idx;
  logic [IDX_W-1:0]    ghr_ext;
  logic [IDX_W-1:0]    idx;
  logic                taken;
  logic                mispredict;
  logic                unused_pc;

  assign unused_pc = ^pc;

  always_comb begin
    base_idx = pc[PC_LSB +: IDX_W];
    ghr_ext  = IDX_W'(ghr_q);
    idx      = (MODE != 0) ? (base_idx ^ ghr_ext) : base_idx;
    taken    = pc_valid & cnt_q[idx][CNT_BITS-1];
  end

  assign pred_taken       = taken;
  assign pred_index       = idx;
  assign pred_ghr         = ghr_q;
  assign flush_pipeline   = flush_q;
  assign stat_branches    = branches_q;
  assign stat_mispredicts = mispredicts_q;

  assign mispredict = upd_valid & (upd_pred_taken != upd_actual_taken);

  // Prediction reads cnt_q, so a same-cycle update to that entry is seen one cycle later.
  always_comb begin
    cnt_d = cnt_q;
    if (upd_valid) begin
      cnt_d[upd_index] = cnt_train(cnt_q[upd_index], upd_actual_taken);
    end
  end

  // Repair wins over the speculative shift: the fetch it would record is being flushed.
  always_comb begin
    ghr_d = ghr_q;
    if (mispredict) begin
      ghr_d = ghr_shift(upd_ghr, upd_actual_taken);
    end else if (pc_valid) begin
      ghr_d = ghr_shift(ghr_q, taken);
    end
  end

  always_comb begin
    flush_d       = mispredict;
    branches_d    = upd_valid  ? stat_inc(branches_q)    : branches_q;
    mispredicts_d = mispredict ? stat_inc(mispredicts_q) : mispredicts_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        cnt_q[i] <= CNT_INIT;
      end
      ghr_q         <= '0;
      flush_q       <= 1'b0;
      branches_q    <= '0;
      mispredicts_q <= '0;
    end else begin
      cnt_q         <= cnt_d;
      ghr_q         <= ghr_d;
      flush_q       <= flush_d;
      branches_q    <= branches_d;
      mispredicts_q <= mispredicts_d;
    end
  end

endmodule

// File: doc/branch_predictor_gshare.md
Name: branch_predictor_gshare

Overview:
Parametrised successor to the single-table 2-bit bimodal predictor used in the fetch stage. It provides a table of N-bit saturating counters indexed either by PC (bimodal) or by PC XOR global history (gshare), with a speculative global history register (GHR) repaired on mispredict. It has an explicit resolve/update port fed from EX, so no internal guessing of pipeline delay is needed. It also drives a registered flush pulse and statistics counters.

Parameters:
ENTRIES, 64, number of counters; power of two, ≥ 4; IDX_W = log2(ENTRIES) is derived.
CNT_BITS, 2, counter width, 2..4.
GHR_BITS, 6, global history length, 1..IDX_W; values above IDX_W are an elaboration error.
MODE, 1, 0 = bimodal (GHR ignored for indexing), 1 = gshare.
PC_LSB, 2, lowest PC bit used in the index; drops byte offset.

Ports:
clk  in  1  clock, all state on posedge
reset  in  1  asynchronous, active-low; clears all state
pc_valid  in  1  fetch presents a branch PC this cycle
pc  in  32  fetch PC
pred_taken  out  1  prediction, combinational, 0 when pc_valid=0
pred_index  out  IDX_W  table index used; carried down the pipe
pred_ghr  out  GHR_BITS  GHR value before this prediction's shift; carried down the pipe
upd_valid  in  1  EX resolves a branch this cycle
upd_index  in  IDX_W  pred_index carried with the branch
upd_ghr  in  GHR_BITS  pred_ghr carried with the branch
upd_pred_taken  in  1  prediction carried with the branch
upd_actual_taken  in  1  resolved outcome
flush_pipeline  out  1  one-cycle mispredict pulse, registered
stat_branches  out  32  resolved-branch count
stat_mispredicts  out  32  mispredict count

Behaviour:
- Reset (async, reset=0):
  - Every counter is set to weakly-not-taken, 2^(CNT_BITS-1)-1 (2'b01 for the default).
  - GHR, flush_pipeline and both stat counters go to 0.
  - pred_taken is 0.
  - Reset asserted mid-operation discards any in-flight update.
- Index:
  - base = pc[PC_LSB+IDX_W-1:PC_LSB].
  - MODE=0: index = base.
  - MODE=1: index = base XOR zero-extended GHR.
- Predict (same cycle, combinational):
  - pred_taken = pc_valid & counter[index][CNT_BITS-1].
  - pred_index and pred_ghr are valid whenever pc_valid=1.
- Speculative GHR: on posedge with pc_valid=1 and no mispredict, GHR <= {GHR[GHR_BITS-2:0], pred_taken}. For GHR_BITS=1, GHR <= pred_taken.
- Update: on posedge with upd_valid=1, counter[upd_index] is trained on every resolve, not only on a mispredict.
  - Increments if upd_actual_taken=1, decrements otherwise.
  - Saturates at all-ones and at 0; no wrap.
- Mispredict: mispredict = upd_valid & (upd_pred_taken != upd_actual_taken).
  - On a mispredict, GHR <= {upd_ghr[GHR_BITS-2:0], upd_actual_taken}.
  - Repair has priority over a same-cycle speculative shift; that fetch's shift is dropped because the younger instruction is flushed.
  - flush_pipeline = 1 for exactly the cycle following the mispredicted update. Back-to-back mispredicts give back-to-back pulses.
- Read/write collision: when pc_valid and upd_valid hit the same index in the same cycle, the prediction uses the pre-update value. The new value is visible from the next cycle.
- Statistics:
  - stat_branches increments on each upd_valid.
  - stat_mispredicts increments on each mispredict.
  - Both saturate at 32'hFFFF_FFFF.
- upd_index, upd_ghr and upd_pred_taken are ignored when upd_valid=0. pc is ignored when pc_valid=0.

Test Plan:
- Reset value: apply reset=0 mid-run with random traffic, then release. Every index must read 2'b01, pred_taken=0 for all PCs, GHR=0, both stats=0, flush_pipeline=0.
- Saturation (MODE=0, defaults): update index 5 with taken four times, then predict pc=0x14. pred_taken=1 and the counter holds 2'b11. Four not-taken updates then give counter 2'b00 with no underflow wrap.
- Mispredict flush and repair: upd_valid with upd_pred_taken=1, upd_actual_taken=0, upd_ghr=6'b101010, issued in the same cycle as pc_valid=1.
  - Next cycle: flush_pipeline=1 for one cycle and GHR=6'b010100.
  - stat_mispredicts=1 and stat_branches=1.
- gshare aliasing split (MODE=1): with GHR=6'b000001, pc=0x100 gives pred_index=1 (base index 0). Training index 1 to taken must not change the prediction at GHR=0.
- Same-cycle collision: counter[3]=01. Predict index 3 while upd_valid trains index 3 taken. pred_taken=0 that cycle and 1 on the next predict.
- Parameter sweep: ENTRIES=16, CNT_BITS=3, GHR_BITS=4 resets every counter to 3'b011. Four taken updates reach 3'b111 and saturate there.
